// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, source indices
// and the fixed-priority ID helper used when INT_CTRL_PRIO_EN is defined.
package int_ctrl_pkg;

    localparam int NSRC = 6;

    localparam logic [2:0] OFF_PEND = 3'd0;
    localparam logic [2:0] OFF_MASK = 3'd1;
    localparam logic [2:0] OFF_MODE = 3'd2;
    localparam logic [2:0] OFF_ID   = 3'd3;
    localparam logic [2:0] OFF_OVR  = 3'd4;

    localparam int SRC_TC0 = 0;
    localparam int SRC_TC1 = 1;
    localparam int SRC_EXT = 2;

    // Lowest set index wins; bit 31 flags that something is pending at all.
    function automatic logic [31:0] prio_id(input logic [NSRC-1:0] v);
        logic [31:0] id;
        id = 32'h0000_0000;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = {1'b1, 28'b0, i[2:0]};
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/int_sync.sv
// Per-source 2-flop synchronizer with a history flop; o_rise marks a new
// synchronized rising edge for one cycle.
module int_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_src,
    output logic o_level,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_src;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: per-source sync/edge detect, PEND/MASK/MODE/OVR registers
// and an optional fixed-priority ID encoder compiled in with INT_CTRL_PRIO_EN.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [5:0] MODE_RST = 6'b000000,
    parameter logic [5:0] MASK_RST = 6'b000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic [5:0]  src,
    output logic [5:0]  int_req
);

    logic [5:0]  r_pend;
    logic [5:0]  r_mask;
    logic [5:0]  r_mode;
    logic [5:0]  r_ovr;

    logic [5:0]  w_level;
    logic [5:0]  w_rise;
    logic [2:0]  w_sel;
    logic        w_wr_pend;
    logic        w_wr_mask;
    logic        w_wr_mode;
    logic        w_wr_ovr;
    logic [5:0]  w_pend_clr;
    logic [5:0]  w_pend_nxt;
    logic [5:0]  w_ovr_set;
    logic [5:0]  w_ovr_nxt;
    logic [31:0] w_id;
    logic        w_unused;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        int_sync u_sync (
            .clk     (clk),
            .reset   (reset),
            .i_src   (src[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_sel     = Addr[4:2];
    assign w_wr_pend = WE & (w_sel == OFF_PEND);
    assign w_wr_mask = WE & (w_sel == OFF_MASK);
    assign w_wr_mode = WE & (w_sel == OFF_MODE);
    assign w_wr_ovr  = WE & (w_sel == OFF_OVR);
    assign w_unused  = &{1'b0, Addr[31:5], Din[31:6]};

    // W1C only acts on edge-mode bits, and a fresh edge always overrides it.
    assign w_pend_clr = {6{w_wr_pend}} & Din[5:0] & r_mode;
    assign w_pend_nxt = (~r_mode & w_level)
                      | ( r_mode & (w_rise | (r_pend & ~w_pend_clr)));
    assign w_ovr_set  = r_mode & w_rise & r_pend & ~w_pend_clr;
    assign w_ovr_nxt  = w_ovr_set | (r_ovr & ~({6{w_wr_ovr}} & Din[5:0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 6'b0;
            r_ovr  <= 6'b0;
            r_mask <= MASK_RST;
            r_mode <= MODE_RST;
        end else begin
            r_pend <= w_pend_nxt;
            r_ovr  <= w_ovr_nxt;
            if (w_wr_mask) r_mask <= Din[5:0];
            if (w_wr_mode) r_mode <= Din[5:0];
        end
    end

    assign int_req = r_pend & r_mask;

`ifdef INT_CTRL_PRIO_EN
    assign w_id = prio_id(int_req);
`else
    assign w_id = 32'h0000_0000;
`endif

    always_comb begin
        Dout = 32'h0000_0000;
        case (w_sel)
            OFF_PEND: Dout = {26'b0, r_pend};
            OFF_MASK: Dout = {26'b0, r_mask};
            OFF_MODE: Dout = {26'b0, r_mode};
            OFF_ID:   Dout = w_id;
            OFF_OVR:  Dout = {26'b0, r_ovr};
            default:  Dout = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: drivers queue expected read/int_req values and a
// negedge monitor pops and compares them.
module tb_int_ctrl;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  src;
    logic [5:0]  int_req;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        chk_valid;
    logic        chk_irq;
    logic        drain_fail;
    logic        drain_done;
    int          checks;
    int          failures;

    localparam logic [2:0] A_PEND = 3'd0;
    localparam logic [2:0] A_MASK = 3'd1;
    localparam logic [2:0] A_MODE = 3'd2;
    localparam logic [2:0] A_ID   = 3'd3;
    localparam logic [2:0] A_OVR  = 3'd4;

`ifdef INT_CTRL_PRIO_EN
    localparam logic [31:0] ID_ALL  = 32'h8000_0002;
    localparam logic [31:0] ID_MSK  = 32'h8000_0004;
`else
    localparam logic [31:0] ID_ALL  = 32'h0000_0000;
    localparam logic [31:0] ID_MSK  = 32'h0000_0000;
`endif

    int_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .src     (src),
        .int_req (int_req)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor / scoreboard
    initial begin
        checks     = 0;
        failures   = 0;
        drain_done = 1'b0;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] got;
        string       n;
        if (chk_valid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL scoreboard: check issued with nothing expected");
            end else begin
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                got = chk_irq ? {26'b0, int_req} : Dout;
                if (got !== e) begin
                    failures = failures + 1;
                    $display("FAIL %s: got %h expected %h", n, got, e);
                end
            end
        end else if (drain_fail && !drain_done) begin
            checks     = checks + 1;
            failures   = failures + 1;
            drain_done = 1'b1;
            $display("FAIL drain: %0d expected values never checked", exp_q.size());
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        Addr = {27'b0, off};
        Din  = d;
        WE   = 1'b1;
        tick(1);
        WE   = 1'b0;
    endtask

    task automatic chk(input logic irq, input logic [2:0] off, input logic [31:0] e, input string n);
        Addr    = {27'b0, off};
        chk_irq = irq;
        exp_q.push_back(e);
        name_q.push_back(n);
        chk_valid = 1'b1;
        tick(1);
        chk_valid = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] e, input string n);
        chk(1'b0, off, e, n);
    endtask

    task automatic irq(input logic [5:0] e, input string n);
        chk(1'b1, A_PEND, {26'b0, e}, n);
    endtask

    task automatic pulse0();
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(4);
    endtask

    // stimulus
    initial begin
        reset      = 1'b1;
        WE         = 1'b0;
        Addr       = '0;
        Din        = '0;
        src        = '0;
        chk_valid  = 1'b0;
        chk_irq    = 1'b0;
        drain_fail = 1'b0;
        tick(2);
        irq(6'h00, "irq_in_reset");
        reset = 1'b0;
        irq(6'h00, "irq_after_reset");
        rd(A_PEND, 32'h0, "rst_pend");
        rd(A_MASK, 32'h0, "rst_mask");
        rd(A_MODE, 32'h0, "rst_mode");
        rd(A_OVR,  32'h0, "rst_ovr");
        rd(A_ID,   32'h0, "rst_id");

        // level mode: set on 3rd edge, clear on 3rd edge
        wr(A_MASK, 32'h3F);
        src = 6'b000100;
        irq(6'h00, "lvl_e1");
        irq(6'h00, "lvl_e2");
        irq(6'h00, "lvl_e3");
        irq(6'h04, "lvl_set");
        rd(A_PEND, 32'h04, "lvl_pend");
        src = 6'b000000;
        irq(6'h04, "lvl_hold1");
        irq(6'h04, "lvl_hold2");
        irq(6'h04, "lvl_hold3");
        irq(6'h00, "lvl_clear");

        // edge mode latch and W1C
        wr(A_MODE, 32'h01);
        src[0] = 1'b1;
        tick(3);
        src[0] = 1'b0;
        tick(3);
        rd(A_PEND, 32'h01, "edge_latched");
        irq(6'h01, "edge_irq");
        wr(A_PEND, 32'h01);
        rd(A_PEND, 32'h00, "edge_w1c");
        irq(6'h00, "edge_w1c_irq");

        // W1C ignored on a level-mode bit
        src[2] = 1'b1;
        tick(4);
        wr(A_PEND, 32'h04);
        rd(A_PEND, 32'h04, "lvl_w1c_ignored");
        src[2] = 1'b0;
        tick(4);

        // overrun
        pulse0();
        rd(A_OVR, 32'h00, "ovr_first_edge");
        pulse0();
        rd(A_OVR,  32'h01, "ovr_set");
        rd(A_PEND, 32'h01, "ovr_pend");
        wr(A_OVR, 32'h01);
        rd(A_OVR,  32'h00, "ovr_w1c");
        rd(A_PEND, 32'h01, "ovr_w1c_pend_kept");
        wr(A_PEND, 32'h01);
        rd(A_PEND, 32'h00, "ovr_pend_clr");

        // edge coincident with W1C of the same bit
        pulse0();
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(1);
        wr(A_PEND, 32'h01);
        rd(A_PEND, 32'h01, "set_beats_w1c");
        rd(A_OVR,  32'h00, "no_ovr_when_clearing");
        wr(A_PEND, 32'h01);
        rd(A_PEND, 32'h00, "coinc_cleanup");

        // priority ID and undecoded offsets
        src = 6'b010100;
        tick(4);
        irq(6'h14, "prio_irq_all");
        rd(A_ID, ID_ALL, "id_all");
        wr(A_MASK, 32'h10);
        rd(A_ID, ID_MSK, "id_masked");
        irq(6'h10, "prio_irq_masked");
        rd(3'd5, 32'h0, "undec5_read");
        wr(3'd6, 32'h3F);
        rd(A_MASK, 32'h10, "undec6_mask_kept");
        rd(A_MODE, 32'h01, "undec6_mode_kept");
        rd(3'd7, 32'h0, "undec7_read");

        // reset mid-operation wins over a write
        pulse0();
        pulse0();
        rd(A_OVR, 32'h01, "pre_rst_ovr");
        reset = 1'b1;
        src   = 6'b000000;
        Addr  = {27'b0, A_MASK};
        Din   = 32'h3F;
        WE    = 1'b1;
        tick(1);
        irq(6'h00, "irq_mid_reset");
        reset = 1'b0;
        WE    = 1'b0;
        rd(A_PEND, 32'h0, "mid_rst_pend");
        rd(A_OVR,  32'h0, "mid_rst_ovr");
        rd(A_MASK, 32'h0, "mid_rst_mask");
        rd(A_MODE, 32'h0, "mid_rst_mode");
        irq(6'h00, "mid_rst_irq");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) drain_fail = 1'b1;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter MODE_RST, default 6'b000000, giving the reset value of MODE (1 = edge, 0 = level).
REQ-002 SHALL have parameter MASK_RST, default 6'b000000, giving the reset value of MASK.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Addr, input, 30 bits ([31:2]): word address from the bridge; only Addr[4:2] is decoded.
REQ-006 SHALL have port WE, input, 1 bit: register write enable from the bridge.
REQ-007 SHALL have port Din, input, 32 bits: write data.
REQ-008 SHALL have port Dout, output, 32 bits: read data.
REQ-009 SHALL have port src, input, 6 bits: raw interrupt sources (timer IRQs, external pin), which may be asynchronous.
REQ-010 SHALL have port int_req, output, 6 bits: masked pending vector driven to the CPU intReq input.

Function
REQ-011 SHALL pass each src bit through a 2-flop synchronizer (s1, s2) plus a history flop s3 for edge detection.
REQ-012 SHALL provide a register map at Addr[4:2]:
- 0 PEND: read; W1C in edge mode
- 1 MASK: RW
- 2 MODE: RW
- 3 ID: RO
- 4 OVR: read; W1C
- 5-7: read 0, writes ignored
REQ-013 SHALL use only Din[5:0] and return Dout[31:6] = 0 for registers 0-2 and 4.
REQ-014 SHALL, in level mode (MODE[i]=0), make PEND[i] follow s2[i] each cycle; W1C has no effect.
REQ-015 SHALL, in edge mode, set PEND[i] when s2[i] & ~s3[i], and clear it by a write to offset 0 with Din[i]=1.
REQ-016 SHALL give set priority over W1C when both occur in the same cycle, so PEND[i] stays 1.
REQ-017 SHALL, in edge mode, set sticky OVR[i] when a new edge arrives while PEND[i] is already 1 and is not being cleared that cycle; OVR[i] clears only by W1C.
REQ-018 SHALL drive int_req = PEND & MASK combinationally from registers, with no extra stage.
REQ-019 SHALL assert int_req[i] (edge or level, unmasked) after clock edge k+2 when src[i] is high at edge k.
REQ-020 SHALL make Dout combinational from Addr and current register state; a write is visible on read in the next cycle.
REQ-021 SHALL, on a MODE[i] change level->edge, leave PEND[i] holding its current value; s3 keeps tracking, so a static-high source raises no new edge.
REQ-022 SHALL apply all writes in the cycle WE is sampled high; WE to an undecoded offset changes nothing.

Reset
REQ-023 SHALL, on reset, load s1, s2, s3, PEND and OVR = 0, MASK = MASK_RST and MODE = MODE_RST.
REQ-024 SHALL hold int_req = 0 during and in the cycle after reset when MASK_RST = 0.
REQ-025 SHALL, on reset mid-operation, discard in-flight synchronizer edges; reset wins over any simultaneous WE or edge.

Configuration
REQ-026 SHALL compile in, when INT_CTRL_PRIO_EN is defined, a fixed-priority encoder where ID reads the lowest index i with int_req[i]=1 in Dout[2:0] and Dout[31] = 1 if any is pending, else 32'h0000_0000.
REQ-027 SHALL, when INT_CTRL_PRIO_EN is undefined, omit the encoder and make ID read 0.

Structure
REQ-028 SHALL place register offsets (PEND/MASK/MODE/ID/OVR) and source-index constants (TC0=0, TC1=1, EXT=2) in the shared package.
REQ-029 SHALL place the per-bit synchronizer/edge detector in sub-module int_sync (s1/s2/s3, outputs level and rise), instantiated per source; the register file and encoder stay in int_ctrl.

Verification
REQ-030 SHALL cover: MASK=6'h3F, MODE=0, src=6'b000100 held -> int_req=6'b000100 after 3rd edge; src low -> int_req clears 3 edges later.
REQ-031 SHALL cover: MODE=6'h01, src[0] pulsed 3 cycles -> PEND=1 latched; write offset 0 Din=1 -> PEND=0, int_req=0 next cycle.
REQ-032 SHALL cover: edge-mode, second src[0] edge before clear -> OVR=6'h01; W1C offset 4 -> OVR=0.
REQ-033 SHALL cover: new edge coincident with W1C of same bit -> PEND stays 1.
REQ-034 SHALL cover: INT_CTRL_PRIO_EN defined, PEND=6'b010100, MASK=6'h3F -> ID reads 32'h8000_0002; MASK=6'b010000 -> 32'h8000_0004.
REQ-035 SHALL cover: reset asserted with PEND/OVR nonzero and WE high -> all cleared, MASK/MODE at parameter defaults, int_req=0.
